// File: rtl/cp0_intc_if.sv
// CP0 interrupt controller access bus: mfc0/mtc0 port,
// device IRQ lines and the exception entry/return handshake.
interface cp0_intc_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIN;
  logic        WE;
  logic [29:0] PC;
  logic [5:0]  HWInt;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOUT;

  modport master (
    output A1, A2, DIN, WE, PC,
    output HWInt, EXLSet, EXLClr,
    input  IntReq, EPC, DOUT
  );

  modport slave (
    input  A1, A2, DIN, WE, PC,
    input  HWInt, EXLSet, EXLClr,
    output IntReq, EPC, DOUT
  );
endinterface

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId registers,
// level-sensitive IRQ request and exception PC capture.
module cp0_intc #(
  parameter logic [31:0] PRID   = 32'h2002_0203,
  parameter logic [5:0]  IM_RST = 6'b000000,
  parameter logic        IE_RST = 1'b0
) (
  input logic         CLK_I,
  input logic         RST_I,
  cp0_intc_if.slave   bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [29:0] epc;

  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic [31:0] rd;

  assign wr_sr  = bus.WE && (bus.A2 == 5'd12);
  assign wr_epc = bus.WE && (bus.A2 == 5'd14);

  // Later assignments win: EXLSet beats EXLClr beats mtc0.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      im  <= IM_RST;
      exl <= 1'b0;
      ie  <= IE_RST;
      ip  <= '0;
      epc <= '0;
    end else begin
      ip <= bus.HWInt;
      if (wr_sr) begin
        im  <= bus.DIN[15:10];
        exl <= bus.DIN[1];
        ie  <= bus.DIN[0];
      end
      if (wr_epc)
        epc <= bus.DIN[31:2];
      if (bus.EXLClr)
        exl <= 1'b0;
      if (bus.EXLSet) begin
        exl <= 1'b1;
        epc <= bus.PC;
      end
    end
  end

  assign sr_rd    = {16'h0, im, 8'h0, exl, ie};
  assign cause_rd = {16'h0, ip, 10'h0};

  always_comb begin
    rd = '0;
    unique case (1'b1)
      bus.A1 == 5'd12: rd = sr_rd;
      bus.A1 == 5'd13: rd = cause_rd;
      bus.A1 == 5'd14: rd = {epc, 2'b00};
      bus.A1 == 5'd15: rd = PRID;
      default:         rd = '0;
    endcase
  end

  assign bus.DOUT   = rd;
  assign bus.EPC    = epc;
  assign bus.IntReq = (|(ip & im)) & ie & ~exl;

endmodule
